// File: rtl/pb_uart_rx_mon_if.sv
// Ready/valid byte stream produced by the UART receive monitor.
// Each beat carries one received byte and the index of the line it arrived on.
interface pb_uart_rx_mon_if #(
  parameter int ChanIdW = 1
);
  logic               byte_valid;
  logic               byte_ready;
  logic [7:0]         byte_data;
  logic [ChanIdW-1:0] byte_chan;

  modport master (
    output byte_valid,
    output byte_data,
    output byte_chan,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    input  byte_chan,
    output byte_ready
  );
endinterface

// File: rtl/pb_uart_rx_mon.sv
// Multi-channel UART receive monitor.
// Deserialises NumChan independent UART lines and buffers each line's bytes in
// its own small FIFO. All FIFOs are merged into one ready/valid byte stream by
// a round-robin arbiter, and each byte is tagged with its channel index.
// Per-line sticky flags report frame errors, FIFO overflow and parity errors.
// Optional feature macro: PB_UART_MON_PARITY_EN selects 8E1 framing with a
// parity check. Without it the frame is 8N1 and parity_err_o is tied low.
module pb_uart_rx_mon #(
  parameter int  NumChan   = 2,
  parameter int  FifoDepth = 4,
  localparam int ChanIdW   = (NumChan > 1) ? $clog2(NumChan) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [15:0]        cfg_div_i,
  input  logic [NumChan-1:0] rx_i,
  pb_uart_rx_mon_if.master   byte_if,
  output logic [NumChan-1:0] frame_err_o,
  output logic [NumChan-1:0] overflow_o,
  output logic [NumChan-1:0] parity_err_o,
  input  logic               clear_err_i
);

  localparam int AddrW = $clog2(FifoDepth);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  logic [NumChan-1:0] push;
  logic [NumChan-1:0] pop;
  logic [NumChan-1:0] not_empty;
  logic [NumChan-1:0] frame_set;
  logic [NumChan-1:0] ovf_set;
  logic [7:0]         head_data [NumChan];
  logic [15:0]        div_eff;

  logic [NumChan-1:0] frame_err_q;
  logic [NumChan-1:0] overflow_q;

  logic [ChanIdW-1:0] rr_q;
  logic [ChanIdW-1:0] lock_grant_q;
  logic               lock_q;
  logic [ChanIdW-1:0] grant;
  logic               valid;
  logic               handshake;

  // Very short bit periods cannot be sampled mid-bit; clamp to 4 cycles.
  assign div_eff = (cfg_div_i < 16'd4) ? 16'd4 : cfg_div_i;

`ifdef PB_UART_MON_PARITY_EN
  logic [NumChan-1:0] parity_set;
  logic [NumChan-1:0] parity_err_q;
`endif

  for (genvar ch = 0; ch < NumChan; ch++) begin : g_chan
    logic [1:0]     sync_q;
    logic           rx_s;
    rx_state_e      state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [15:0]    div_q, div_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           push_l;
    logic           frame_set_l;
    logic [7:0]     mem_q [FifoDepth];
    logic [AddrW:0] wptr_q, rptr_q;
    logic           full_l;
    logic           wr_en;
`ifdef PB_UART_MON_PARITY_EN
    logic           par_set_l;
`endif

    assign rx_s = sync_q[1];

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= 2'b11;
      else         sync_q <= {sync_q[0], rx_i[ch]};
    end

    // Frame FSM: mid-bit sampling driven by a reloadable down-counter
    always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q != 16'd0) ? cnt_q - 16'd1 : cnt_q;
      div_d       = div_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      push_l      = 1'b0;
      frame_set_l = 1'b0;
`ifdef PB_UART_MON_PARITY_EN
      par_set_l   = 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d = ST_START;
            div_d   = div_eff;
            cnt_d   = (div_eff >> 1) - 16'd1;
          end
        end
        ST_START: begin
          if (cnt_q == 16'd0) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              cnt_d   = div_q - 16'd1;
              bit_d   = 3'd0;
            end else begin
              // Start bit gone by mid-bit: treat as a glitch
              state_d = ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (cnt_q == 16'd0) begin
            shift_d = {rx_s, shift_q[7:1]};
            cnt_d   = div_q - 16'd1;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef PB_UART_MON_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end
`ifdef PB_UART_MON_PARITY_EN
        ST_PARITY: begin
          if (cnt_q == 16'd0) begin
            cnt_d     = div_q - 16'd1;
            state_d   = ST_STOP;
            par_set_l = (rx_s != ^shift_q);
          end
        end
`endif
        ST_STOP: begin
          if (cnt_q == 16'd0) begin
            if (rx_s) begin
              push_l  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              frame_set_l = 1'b1;
              state_d     = ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // FSM control state
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= ST_IDLE;
        cnt_q   <= 16'd0;
        bit_q   <= 3'd0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        bit_q   <= bit_d;
      end
    end

    // Latched divider and shift register hold data only, no reset needed
    always_ff @(posedge clk_i) begin
      div_q   <= div_d;
      shift_q <= shift_d;
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign full_l = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                    (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
    assign wr_en  = push_l && (!full_l || pop[ch]);

    // FIFO pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (wr_en)   wptr_q <= wptr_q + 1'b1;
        if (pop[ch]) rptr_q <= rptr_q + 1'b1;
      end
    end

    // FIFO storage
    always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wptr_q[AddrW-1:0]] <= shift_q;
    end

    assign head_data[ch] = mem_q[rptr_q[AddrW-1:0]];
    assign not_empty[ch] = (wptr_q != rptr_q);
    assign push[ch]      = push_l;
    assign frame_set[ch] = frame_set_l;
    assign ovf_set[ch]   = push_l && full_l && !pop[ch];
    assign pop[ch]       = handshake && (grant == ChanIdW'(ch));
`ifdef PB_UART_MON_PARITY_EN
    assign parity_set[ch] = par_set_l;
`endif
  end

  // Round-robin pick from rr_q; a stalled beat keeps its grant until accepted
  always_comb begin
    grant = rr_q;
    // Lowest non-empty channel overall covers the wrap-around case
    for (int i = NumChan - 1; i >= 0; i--) begin
      if (not_empty[i]) grant = ChanIdW'(i);
    end
    // Lowest non-empty channel at or above the pointer takes precedence
    for (int i = NumChan - 1; i >= 0; i--) begin
      if (not_empty[i] && (ChanIdW'(i) >= rr_q)) grant = ChanIdW'(i);
    end
    if (lock_q) grant = lock_grant_q;
  end

  assign valid     = |not_empty;
  assign handshake = valid && byte_if.byte_ready;

  assign byte_if.byte_valid = valid;
  assign byte_if.byte_data  = valid ? head_data[grant] : 8'd0;
  assign byte_if.byte_chan  = valid ? grant : '0;

  // Arbiter pointer and grant lock
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q         <= '0;
      lock_q       <= 1'b0;
      lock_grant_q <= '0;
    end else begin
      lock_q       <= valid && !byte_if.byte_ready;
      lock_grant_q <= grant;
      if (handshake) begin
        rr_q <= (grant == ChanIdW'(NumChan - 1)) ? '0 : grant + ChanIdW'(1);
      end
    end
  end

  // Sticky error flags; a new event in the same cycle wins over clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_err_q <= '0;
      overflow_q  <= '0;
    end else begin
      frame_err_q <= (frame_err_q & ~{NumChan{clear_err_i}}) | frame_set;
      overflow_q  <= (overflow_q  & ~{NumChan{clear_err_i}}) | ovf_set;
    end
  end

  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;

`ifdef PB_UART_MON_PARITY_EN
  // Sticky parity error flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) parity_err_q <= '0;
    else         parity_err_q <= (parity_err_q & ~{NumChan{clear_err_i}}) | parity_set;
  end

  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = '0;
`endif

endmodule
